lsu: RTL
========

Name: lsu

Overview:
- Load/store stage directly downstream of the execute stage.
- Consumes the ALU result as the effective address (or as pass-through writeback data) plus rs2 store data.
- Runs one request/grant/response transaction on a single-port data memory and presents aligned, sign/zero-extended writeback data to the writeback stage via valid/ready.
- One instruction in flight; 32-bit data path.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): datapath width; only 32 supported; elaboration error otherwise.
- ADDR_WIDTH, 32: memory byte-address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction.
- i_ld_en  in  1  instruction is a load.
- i_st_en  in  1  instruction is a store; i_ld_en and i_st_en both high is illegal.
- i_lsu_func  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_alu_res  in  DATA_WIDTH  address for load/store; writeback data otherwise.
- i_rs2_data  in  DATA_WIDTH  store data.
- o_mem_req  out  1  memory request.
- i_mem_gnt  in  1  request accepted.
- o_mem_we  out  1  write request.
- o_mem_addr  out  ADDR_WIDTH  word-aligned address; low 2 bits always 0.
- o_mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- o_mem_wmask  out  DATA_WIDTH/8  byte write strobes.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  DATA_WIDTH  read word.
- o_valid  out  1  writeback data valid.
- i_ready  in  1  writeback stage accepts.
- o_wb_data  out  DATA_WIDTH  writeback value.
- o_lsu_err  out  1  misaligned access flag, qualified by o_valid.

Behaviour:
- Reset: state IDLE; all outputs 0 except o_ready=1. All captured registers cleared.
- States: IDLE, REQ, WAIT, DONE. o_ready = (state==IDLE).

IDLE:
- Accept on i_valid && o_ready. Capture func, address, store data, ld/st flags.
- Non-memory op -> DONE with o_wb_data = i_alu_res. Latency 1 cycle.
- Misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0) -> DONE with o_lsu_err=1 and o_wb_data=0. No memory request is issued.
- Otherwise -> REQ.

REQ:
- o_mem_req=1; o_mem_we=st; addr/wdata/wmask held stable.
- Stays in REQ until i_mem_gnt.
- On gnt: store -> DONE; load -> WAIT.
- o_mem_req drops in the cycle after gnt.

WAIT:
- Stays until i_mem_rvalid.
- Captures the extracted byte/half/word, sign- or zero-extended per func, into o_wb_data -> DONE.
- rvalid is ignored in any state other than WAIT, including the grant cycle.
- Minimum load latency from accept to o_valid is 3 cycles.

DONE:
- o_valid=1; o_wb_data and o_lsu_err held until i_valid-free handshake i_ready=1 -> IDLE.
- A store completes with o_wb_data=0.
- No new accept occurs in the DONE->IDLE cycle; throughput is at most one instruction per 2 cycles.

Store lanes:
- SB: wmask = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
- SH: wmask = 0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
- SW: wmask = 1111.
- o_mem_wmask is 0 whenever o_mem_req=0.

Reset and illegal inputs:
- Reset mid-transaction: returns to IDLE immediately. o_mem_req deasserts asynchronously. Any later rvalid is ignored.
- Illegal func code: treated as W.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses are flagged via o_lsu_err and skip memory, as above.
- Undefined: no misalignment check. o_lsu_err is tied 0. Offending low address bits are forced to 0 (H: addr[0]; W: addr[1:0]) and the access proceeds normally.

Decomposition:
- Shared package/cfg include: LSU funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and the lsu_state_t enum.
- One combinational sub-module, lsu_align: computes wmask/wdata from func+addr and load extraction/extension from rdata+func+addr[1:0].

Test Plan:
- LBU addr 0x1003, rdata 0x80FF_1234, gnt delayed 2 cycles -> o_mem_addr=0x1000, o_mem_req held 3 cycles, o_wb_data=0x0000_0080.
- LH addr 0x2002, rdata 0x8001_0000 -> o_wb_data=0xFFFF_8001. LHU of the same -> 0x0000_8001.
- SB addr 0x3001, rs2=0xDEAD_BEEF -> o_mem_we=1, wmask=0010, wdata=0xEFEF_EFEF, o_valid one cycle after gnt, o_wb_data=0.
- LW addr 0x4002 with trap enabled -> no o_mem_req, o_valid with o_lsu_err=1. With the macro undefined -> o_mem_addr=0x4000, o_lsu_err=0.
- Non-memory op alu_res=0x1234_5678 with i_ready low 4 cycles -> o_valid and o_wb_data stable, o_ready=0 throughout, accept resumes after handshake.
- Assert i_rst_n low while in WAIT, then pulse rvalid -> o_mem_req=0 and o_valid=0 immediately, o_ready=1, stray rvalid ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, FSM states and address alignment helpers.
// Data width is fixed at 32; other widths are rejected at elaboration by lsu.
package lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;
    localparam int LSU_ADDR_WIDTH = 32;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} lsu_size_t;

    // Unknown funct3 encodings behave as a word access
    function automatic lsu_size_t lsu_size(input logic [2:0] func);
        case (func)
            LSU_B, LSU_BU: lsu_size = SIZE_B;
            LSU_H, LSU_HU: lsu_size = SIZE_H;
            default:       lsu_size = SIZE_W;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] func, input logic [1:0] addr_lo);
        case (lsu_size(func))
            SIZE_H:  lsu_misaligned = addr_lo[0];
            SIZE_W:  lsu_misaligned = |addr_lo;
            default: lsu_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] lsu_force_align(input logic [2:0] func, input logic [1:0] addr_lo);
        case (lsu_size(func))
            SIZE_H:  lsu_force_align = {addr_lo[1], 1'b0};
            SIZE_W:  lsu_force_align = 2'b00;
            default: lsu_force_align = addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU's upstream, data-memory and writeback handshake signals.
// The slave modport is the LSU's view; master is the surrounding pipeline/memory.
interface lsu_if import lsu_pkg::*; #(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
);
    logic                    i_valid;
    logic                    o_ready;
    logic                    i_ld_en;
    logic                    i_st_en;
    logic [2:0]              i_lsu_func;
    logic [DATA_WIDTH-1:0]   i_alu_res;
    logic [DATA_WIDTH-1:0]   i_rs2_data;

    logic                    o_mem_req;
    logic                    i_mem_gnt;
    logic                    o_mem_we;
    logic [ADDR_WIDTH-1:0]   o_mem_addr;
    logic [DATA_WIDTH-1:0]   o_mem_wdata;
    logic [DATA_WIDTH/8-1:0] o_mem_wmask;
    logic                    i_mem_rvalid;
    logic [DATA_WIDTH-1:0]   i_mem_rdata;

    logic                    o_valid;
    logic                    i_ready;
    logic [DATA_WIDTH-1:0]   o_wb_data;
    logic                    o_lsu_err;

    modport slave (
        input  i_valid, i_ld_en, i_st_en, i_lsu_func, i_alu_res, i_rs2_data,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_ready,
        output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        output o_valid, o_wb_data, o_lsu_err
    );

    modport master (
        output i_valid, i_ld_en, i_st_en, i_lsu_func, i_alu_res, i_rs2_data,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_ready,
        input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        input  o_valid, o_wb_data, o_lsu_err
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for a 32-bit word memory: store strobes/replicated data and
// load byte/half extraction with sign or zero extension.
module lsu_align import lsu_pkg::*; (
    input  logic [2:0]  func,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;
    logic        sign_ext;

    assign shifted  = rdata >> {addr_lo, 3'b000};
    assign sign_ext = ~func[2];

    always_comb begin
        wmask   = 4'b1111;
        wdata   = st_data;
        ld_data = shifted;
        case (lsu_size(func))
            SIZE_B: begin
                wmask   = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                wmask   = 4'b0011 << addr_lo;
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wmask   = 4'b1111;
                wdata   = st_data;
                ld_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one instruction in flight, request/grant/rvalid data memory, valid/ready writeback.
// Optional macro LSU_MISALIGN_TRAP_EN: flag misaligned accesses instead of force-aligning them.
module lsu import lsu_pkg::*; #(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
    input logic  i_clk,
    input logic  i_rst_n,
    lsu_if.slave bus
);

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("lsu: only DATA_WIDTH = 32 is supported");
        end
    endgenerate

    lsu_state_t            state;
    logic [2:0]            func_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rs2_q;
    logic                  st_q;
    logic                  ready;
    logic                  valid;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  lsu_err;

    logic                  is_mem;
    logic                  misaligned;
    logic [1:0]            acc_lo;
    logic [3:0]            lane_mask;
    logic [31:0]           lane_wdata;
    logic [31:0]           ld_data;

    assign is_mem = bus.i_ld_en | bus.i_st_en;

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_lo     = bus.i_alu_res[1:0];
    assign misaligned = lsu_misaligned(bus.i_lsu_func, bus.i_alu_res[1:0]);
`else
    assign acc_lo     = lsu_force_align(bus.i_lsu_func, bus.i_alu_res[1:0]);
    assign misaligned = 1'b0;
`endif

    // Lanes come from captured values so they stay stable for the whole request
    lsu_align u_align (
        .func    (func_q),
        .addr_lo (addr_q[1:0]),
        .st_data (rs2_q),
        .rdata   (bus.i_mem_rdata),
        .wmask   (lane_mask),
        .wdata   (lane_wdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            func_q  <= '0;
            addr_q  <= '0;
            rs2_q   <= '0;
            st_q    <= 1'b0;
            ready   <= 1'b1;
            valid   <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            wb_data <= '0;
            lsu_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        func_q <= bus.i_lsu_func;
                        addr_q <= {bus.i_alu_res[ADDR_WIDTH-1:2], acc_lo};
                        rs2_q  <= bus.i_rs2_data;
                        st_q   <= bus.i_st_en;
                        ready  <= 1'b0;
                        if (!is_mem) begin
                            wb_data <= bus.i_alu_res;
                            valid   <= 1'b1;
                            state   <= DONE;
                        end else if (misaligned) begin
                            wb_data <= '0;
                            lsu_err <= 1'b1;
                            valid   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= bus.i_st_en;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.i_mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (st_q) begin
                            wb_data <= '0;
                            valid   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.i_mem_rvalid) begin
                        wb_data <= ld_data;
                        valid   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid   <= 1'b0;
                        ready   <= 1'b1;
                        lsu_err <= 1'b0;
                        wb_data <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid;
    assign bus.o_wb_data   = wb_data;
    assign bus.o_lsu_err   = lsu_err;
    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_we    = mem_we;
    assign bus.o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.o_mem_wdata = lane_wdata;
    assign bus.o_mem_wmask = (mem_req && mem_we) ? lane_mask : '0;

endmodule
